// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//
// Input stage for the stopwatch: brings the raw, bouncing pause (btnS) and
// reset (btnR) pushbuttons into the clk domain, debounces each one with its
// own counter-based state machine, and turns the results into the control
// signals the counting/display logic consumes.
//
// Ports:
//   clk          system clock, all state changes on the rising edge
//   RESET_n      asynchronous active-low reset
//   btnS         raw pause button (active high, asynchronous to clk)
//   btnR         raw reset button (active high, asynchronous to clk)
//   paused       level, 1 = counting halted; toggles per accepted btnS press,
//                forced to 0 by an accepted btnR press
//   pause_pulse  one-cycle strobe per accepted btnS press
//   clear_pulse  one-cycle strobe per accepted btnR press
//   clear_hold   level, 1 while btnR is debounced-held
// -----------------------------------------------------------------------------
module button_conditioner #(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 1000000,
  parameter int CNT_W       = 20
) (
  input  logic clk,
  input  logic RESET_n,
  input  logic btnS,
  input  logic btnR,
  output logic paused,
  output logic pause_pulse,
  output logic clear_pulse,
  output logic clear_hold
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMING    = 2'd1,
    HELD      = 2'd2,
    RELEASING = 2'd3
  } db_state_t;

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Index 0 = btnS (pause), index 1 = btnR (clear).
  logic [1:0] btn_raw;
  logic [1:0] press_now;    // combinational: press accepted on this edge
  logic [1:0] press_pulse;  // registered one-cycle strobes
  logic       paused_reg;
  logic       clear_hold_reg;

  assign btn_raw = {btnR, btnS};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn
      logic [SYNC_STAGES-1:0] sync_reg;
      logic                   s_sync;
      db_state_t              state_reg;
      db_state_t              state_next;
      logic [CNT_W-1:0]       cnt_reg;
      logic [CNT_W-1:0]       cnt_next;
      logic                   strobe_reg;
      logic                   press_hit;

      // Synchronizer chain; the FSM only ever looks at the last stage.
      always_ff @(posedge clk or negedge RESET_n) begin
        if (!RESET_n) begin
          sync_reg <= '0;
        end else begin
          sync_reg <= {sync_reg[SYNC_STAGES-2:0], btn_raw[gi]};
        end
      end

      assign s_sync = sync_reg[SYNC_STAGES-1];

      // State register.
      always_ff @(posedge clk or negedge RESET_n) begin
        if (!RESET_n) begin
          state_reg  <= IDLE;
          cnt_reg    <= '0;
          strobe_reg <= 1'b0;
        end else begin
          state_reg  <= state_next;
          cnt_reg    <= cnt_next;
          strobe_reg <= press_hit;
        end
      end

      // Next-state logic. The counter is only decremented while nonzero, so
      // it can never wrap.
      always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
          IDLE: begin
            if (s_sync) begin
              state_next = ARMING;
              cnt_next   = LOAD_VAL;
            end
          end
          ARMING: begin
            if (!s_sync) begin
              state_next = IDLE;
            end else if (cnt_reg == '0) begin
              state_next = HELD;
            end else begin
              cnt_next = cnt_reg - CNT_ONE;
            end
          end
          HELD: begin
            if (!s_sync) begin
              state_next = RELEASING;
              cnt_next   = LOAD_VAL;
            end
          end
          RELEASING: begin
            if (s_sync) begin
              state_next = HELD;
            end else if (cnt_reg == '0) begin
              state_next = IDLE;
            end else begin
              cnt_next = cnt_reg - CNT_ONE;
            end
          end
          default: begin
            state_next = IDLE;
          end
        endcase
      end

      // Output logic: a press is accepted only on the ARMING->HELD edge, so a
      // button held indefinitely yields a single strobe.
      always_comb begin
        press_hit = (state_reg == ARMING) && s_sync && (cnt_reg == '0);
      end

      assign press_now[gi]   = press_hit;
      assign press_pulse[gi] = strobe_reg;

      // Only the clear button exports a hold level. It is registered from
      // state_next so it rises together with clear_pulse and falls on the
      // RELEASING->IDLE edge.
      if (gi == 1) begin : g_hold
        always_ff @(posedge clk or negedge RESET_n) begin
          if (!RESET_n) begin
            clear_hold_reg <= 1'b0;
          end else begin
            clear_hold_reg <= (state_next == HELD) || (state_next == RELEASING);
          end
        end
      end
    end
  endgenerate

  // Clear dominates a same-edge pause press; the pause strobe itself is
  // still emitted.
  always_ff @(posedge clk or negedge RESET_n) begin
    if (!RESET_n) begin
      paused_reg <= 1'b0;
    end else if (press_now[1]) begin
      paused_reg <= 1'b0;
    end else if (press_now[0]) begin
      paused_reg <= ~paused_reg;
    end
  end

  assign paused      = paused_reg;
  assign pause_pulse = press_pulse[0];
  assign clear_pulse = press_pulse[1];
  assign clear_hold  = clear_hold_reg;

endmodule

// File: tb/tb_button_conditioner.sv
// -----------------------------------------------------------------------------
// tb_button_conditioner
//
// Directed scenarios followed by a randomized phase. Expected outputs come from
// a reference model that treats each button as "debounced level flips once the
// synchronized input has disagreed with it for DB+1 consecutive samples".
// -----------------------------------------------------------------------------
module tb_button_conditioner;

  localparam int SYNC = 2;
  localparam int DB   = 4;
  localparam int CW   = 20;

  logic clk     = 1'b0;
  logic RESET_n = 1'b0;
  logic btnS    = 1'b0;
  logic btnR    = 1'b0;
  logic paused;
  logic pause_pulse;
  logic clear_pulse;
  logic clear_hold;

  always #5 clk = ~clk;

  button_conditioner #(
    .SYNC_STAGES(SYNC),
    .DB_CYCLES  (DB),
    .CNT_W      (CW)
  ) dut (
    .clk        (clk),
    .RESET_n    (RESET_n),
    .btnS       (btnS),
    .btnR       (btnR),
    .paused     (paused),
    .pause_pulse(pause_pulse),
    .clear_pulse(clear_pulse),
    .clear_hold (clear_hold)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state (index 0 = S, 1 = R)
  logic [SYNC-1:0] pipe_m [2];
  logic            db_m   [2];
  int              run_m  [2];
  logic            pulse_m[2];
  logic            paused_m;

  // Per-scenario bookkeeping
  int cyc;
  int ns_cnt, nr_cnt, first_s, first_r, same_cycle;

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < 2; b++) begin
      pipe_m[b]  = '0;
      db_m[b]    = 1'b0;
      run_m[b]   = 0;
      pulse_m[b] = 1'b0;
    end
    paused_m = 1'b0;
  endtask

  // Called at each rising edge with the input values seen by that edge.
  task automatic model_edge();
    logic s;
    logic raw;
    if (!RESET_n) begin
      model_reset();
      return;
    end
    for (int b = 0; b < 2; b++) begin
      raw = (b == 0) ? btnS : btnR;
      s = pipe_m[b][SYNC-1];
      pulse_m[b] = 1'b0;
      if (s != db_m[b]) begin
        run_m[b]++;
        if (run_m[b] == DB + 1) begin
          db_m[b]    = s;
          run_m[b]   = 0;
          pulse_m[b] = s;
        end
      end else begin
        run_m[b] = 0;
      end
      pipe_m[b] = {pipe_m[b][SYNC-2:0], raw};
    end
    if (pulse_m[1])      paused_m = 1'b0;
    else if (pulse_m[0]) paused_m = ~paused_m;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".pause_pulse"}, pause_pulse, pulse_m[0]);
    check({tag, ".clear_pulse"}, clear_pulse, pulse_m[1]);
    check({tag, ".clear_hold"},  clear_hold,  db_m[1]);
    check({tag, ".paused"},      paused,      paused_m);
  endtask

  task automatic clear_stats();
    cyc = 0; ns_cnt = 0; nr_cnt = 0;
    first_s = -1; first_r = -1; same_cycle = 0;
  endtask

  // One clock: model the edge, sample 1 time unit later.
  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    check_outputs(tag);
    if (pause_pulse) begin
      ns_cnt++;
      if (first_s < 0) first_s = cyc;
    end
    if (clear_pulse) begin
      nr_cnt++;
      if (first_r < 0) first_r = cyc;
    end
    if (pause_pulse && clear_pulse) same_cycle++;
  endtask

  task automatic steps(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  initial begin
    int hs, hr;

    // Reset state
    model_reset();
    #1;
    check_outputs("reset");
    steps("reset", 2);
    RESET_n = 1'b1;
    steps("idle", 5);

    // 1. Clean press: strobe 7 edges after the rise, exactly once
    clear_stats();
    btnS = 1'b1;
    steps("t1_press", 20);
    check_int("t1_strobe_edge", first_s, 7);
    check_int("t1_strobe_count", ns_cnt, 1);
    check("t1_paused", paused, 1'b1);
    btnS = 1'b0;
    steps("t1_release", 20);
    btnS = 1'b1;
    steps("t1_press2", 20);
    btnS = 1'b0;
    steps("t1_release2", 20);
    check("t1_paused2", paused, 1'b0);

    // 2. Bounce rejection
    clear_stats();
    btnS = 1'b1; steps("t2", 3);
    btnS = 1'b0; steps("t2", 2);
    btnS = 1'b1; steps("t2", 3);
    btnS = 1'b0; steps("t2", 20);
    check_int("t2_strobe_count", ns_cnt, 0);
    check("t2_paused", paused, 1'b0);

    // 3. Release bounce
    clear_stats();
    btnS = 1'b1; steps("t3", 12);
    btnS = 1'b0; steps("t3", 2);
    btnS = 1'b1; steps("t3", 2);
    btnS = 1'b0; steps("t3", 20);
    check_int("t3_strobe_count", ns_cnt, 1);
    check("t3_paused", paused, 1'b1);

    // 4. Clear while paused; clear_hold extends 7 edges past btnR falling
    clear_stats();
    btnR = 1'b1; steps("t4", 10);
    check_int("t4_clear_edge", first_r, 7);
    check("t4_paused", paused, 1'b0);
    check("t4_hold_high", clear_hold, 1'b1);
    btnR = 1'b0;
    clear_stats();
    steps("t4_rel", 6);
    check("t4_hold_6", clear_hold, 1'b1);
    step("t4_rel");
    check("t4_hold_7", clear_hold, 1'b0);
    steps("t4_rel", 10);

    // 5. Simultaneous press with paused=0
    clear_stats();
    btnS = 1'b1; btnR = 1'b1;
    steps("t5", 12);
    check_int("t5_same_cycle", same_cycle, 1);
    check("t5_paused", paused, 1'b0);
    btnS = 1'b0; btnR = 1'b0;
    steps("t5_rel", 15);

    // 6. Reset during ARMING, button still held after release
    btnS = 1'b1;
    steps("t6_arm", 4);
    RESET_n = 1'b0;
    #1;
    model_reset();
    check_outputs("t6_in_reset");
    steps("t6_in_reset", 2);
    RESET_n = 1'b1;
    clear_stats();
    steps("t6_after", 10);
    check_int("t6_strobe_edge", first_s, 7);
    check("t6_paused", paused, 1'b1);
    btnS = 1'b0;
    steps("t6_rel", 15);

    // Randomized phase
    hs = 1; hr = 1;
    for (int i = 0; i < 1500; i++) begin
      hs--; hr--;
      if (hs == 0) begin
        btnS = ~btnS;
        hs = $urandom_range(1, 12);
      end
      if (hr == 0) begin
        btnR = ~btnR;
        hr = $urandom_range(1, 20);
      end
      if ($urandom_range(0, 299) == 0) begin
        RESET_n = 1'b0;
        #1;
        model_reset();
        check_outputs("rand_reset");
        steps("rand_reset", 2);
        RESET_n = 1'b1;
      end
      step("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Front-end input stage that feeds the stopwatch counting and display logic.
- Takes raw, bouncing btnS (pause) and btnR (reset) pushbutton levels and synchronizes them to clk.
- Debounces each button with its own counter-based state machine.
- Produces a clean pause/run level (toggled per btnS press), a one-cycle clear pulse and a debounced clear-hold level for btnR.

Parameters:
- SYNC_STAGES, 2, number of flip-flops in each input synchronizer chain (minimum 2).
- DB_CYCLES, 1000000, clk cycles the synchronized input must stay stable to be accepted. Default is 10 ms at 100 MHz; benches use 4.
- CNT_W, 20, debounce counter width. Must satisfy 2^CNT_W > DB_CYCLES.

Ports:
- clk  input  1  100 MHz system clock; all state changes on the rising edge.
- RESET_n  input  1  asynchronous, active-low reset.
- btnS  input  1  raw pause button, active high, asynchronous to clk.
- btnR  input  1  raw reset button, active high, asynchronous to clk.
- paused  output  1  registered level; 1 = counting halted, 0 = running.
- pause_pulse  output  1  registered one-cycle strobe on each accepted btnS press.
- clear_pulse  output  1  registered one-cycle strobe on each accepted btnR press.
- clear_hold  output  1  registered level; 1 while btnR is debounced-held.

Behaviour:
Reset:
- RESET_n low asynchronously clears all synchronizer flops, both FSMs to IDLE, both counters to 0, and paused, pause_pulse, clear_pulse, clear_hold to 0.
- Release of RESET_n takes effect on the next rising clk edge.
Synchronizer:
- Each button passes through SYNC_STAGES flops; s_S / s_R denote the last-stage outputs.
- The FSMs sample only s_S / s_R, never the raw pins.
Per-button FSM (two identical, independent instances, each with its own counter):
- IDLE: s=1 -> ARMING, counter loaded with DB_CYCLES-1; otherwise stay.
- ARMING: s=0 -> IDLE (bounce rejected). s=1 and counter==0 -> HELD, assert press strobe for exactly one cycle. s=1 and counter!=0 -> decrement.
- HELD: s=0 -> RELEASING, counter loaded with DB_CYCLES-1; otherwise stay, no further strobes.
- RELEASING: s=1 -> HELD (release bounce rejected, no new strobe). s=0 and counter==0 -> IDLE. Otherwise decrement.
- Counter never underflows; it is only decremented when nonzero.
- Encoding: IDLE=0, ARMING=1, HELD=2, RELEASING=3.
Latency:
- With the input stable from edge 0, the press strobe is high in the cycle after edge SYNC_STAGES+1+DB_CYCLES (7 edges for SYNC_STAGES=2, DB_CYCLES=4).
- Release detection has the same latency; release produces no strobe.
Outputs:
- pause_pulse = S-instance press strobe.
- clear_pulse = R-instance press strobe.
- clear_hold = 1 while the R FSM is in HELD or RELEASING.
- paused toggles on each pause_pulse. paused is forced to 0 on clear_pulse.
- Same-cycle pause_pulse and clear_pulse: clear wins, paused=0, and pause_pulse is still emitted.
Boundaries:
- Holding a button indefinitely yields exactly one strobe.
- A glitch shorter than DB_CYCLES in ARMING or RELEASING never changes the debounced state.
- RESET_n asserted mid-ARMING or mid-HELD discards the press. A button still held after reset release is treated as a fresh press and strobes after full latency.
- btnS and btnR are handled fully independently; either may be held while the other is pressed.

Test Plan (SYNC_STAGES=2, DB_CYCLES=4):
1. Clean press: btnS 0->1 held 20 cycles -> pause_pulse high exactly one cycle, 7 edges after the rise; paused 0->1. Second clean press/release -> paused back to 0.
2. Bounce rejection: btnS pulses high 3 cycles, low 2, high 3, then low -> no pause_pulse, paused stays 0, FSM ends in IDLE.
3. Release bounce: press accepted, then btnS low 2 cycles, high 2 cycles, low 20 cycles -> single pause_pulse total, FSM returns to IDLE.
4. Clear while paused: paused=1, press btnR held 10 cycles -> clear_pulse one cycle, paused=0, clear_hold high from the same cycle until 7 edges after btnR falls.
5. Simultaneous: btnS and btnR rise on the same edge with paused=0 -> pause_pulse and clear_pulse in the same cycle, paused remains 0.
6. Reset mid-operation: btnS high, RESET_n low during ARMING for 2 cycles then high with btnS still high -> all outputs 0 during reset, pause_pulse 7 edges after RESET_n release, paused=1.
